core_seq: RTL and testbench

CORE_SEQ -- requirements
Module: core_seq

---
 rtl/core_seq.sv | 213 +++++++++++++++++++++
 tb/tb_core_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq.sv
// Tile sequencer: emits the per-cycle instruction bundle that loads weights, streams activations and drains results.
// Optional build macro CORE_SEQ_PAUSE_EN adds a pause input that freezes sequencing.
module core_seq #(
    parameter int unsigned row        = 8,
    parameter int unsigned col        = 8,
    parameter int unsigned addr_width = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_width-1:0]    w_base,
    input  logic [addr_width-1:0]    x_base,
    input  logic [addr_width-1:0]    p_base,
    input  logic [addr_width-1:0]    n_act,
    input  logic                     ofifo_valid,
`ifdef CORE_SEQ_PAUSE_EN
    input  logic                     pause,
`endif
    output logic [2*addr_width+11:0] inst,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned FLUSH_LEN = row + col;
    localparam int unsigned FLUSH_W   = $clog2(FLUSH_LEN + 1);
    localparam int unsigned CNT_W     = (addr_width > FLUSH_W) ? addr_width : FLUSH_W;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_W_RD    = 3'd1;
    localparam logic [2:0] S_W_LOAD  = 3'd2;
    localparam logic [2:0] S_W_FLUSH = 3'd3;
    localparam logic [2:0] S_X_RUN   = 3'd4;
    localparam logic [2:0] S_DRAIN   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    typedef struct packed {
        logic                  acc;
        logic                  cen_pmem;
        logic                  wen_pmem;
        logic [addr_width-1:0] a_pmem;
        logic                  cen_xmem;
        logic                  wen_xmem;
        logic [addr_width-1:0] a_xmem;
        logic                  ofifo_rd;
        logic                  ififo_wr;
        logic                  ififo_rd;
        logic                  l0_rd;
        logic                  l0_wr;
        logic                  execute;
        logic                  load;
    } inst_t;

    localparam inst_t INST_NOP = '{cen_pmem: 1'b1, wen_pmem: 1'b1,
                                   cen_xmem: 1'b1, wen_xmem: 1'b1, default: '0};

    logic [2:0]            state_q,   state_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [addr_width-1:0] rd_cnt_q,  rd_cnt_d;
    logic [addr_width-1:0] wr_cnt_q,  wr_cnt_d;
    logic                  wr_pend_q, wr_pend_d;
    logic [addr_width-1:0] w_base_q,  w_base_d;
    logic [addr_width-1:0] x_base_q,  x_base_d;
    logic [addr_width-1:0] p_base_q,  p_base_d;
    logic [addr_width-1:0] n_act_q,   n_act_d;
    inst_t                 inst_q,    inst_d;
    logic                  busy_q,    busy_d;
    logic                  done_q,    done_d;
    logic                  hold;

    // Outputs describe the state of the previous cycle, so ofifo_rd reacts to ofifo_valid one cycle later.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        wr_pend_d = wr_pend_q;
        w_base_d  = w_base_q;
        x_base_d  = x_base_q;
        p_base_d  = p_base_q;
        n_act_d   = n_act_q;
        inst_d    = INST_NOP;
        busy_d    = (state_q != S_IDLE);
        done_d    = 1'b0;
        hold      = 1'b0;
`ifdef CORE_SEQ_PAUSE_EN
        hold      = pause && (state_q != S_IDLE);
`endif
        if (!hold) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d   = S_W_RD;
                        cnt_d     = '0;
                        rd_cnt_d  = '0;
                        wr_cnt_d  = '0;
                        wr_pend_d = 1'b0;
                        w_base_d  = w_base;
                        x_base_d  = x_base;
                        p_base_d  = p_base;
                        n_act_d   = n_act;
                    end
                end
                S_W_RD: begin
                    if (cnt_q < CNT_W'(row)) begin
                        inst_d.cen_xmem = 1'b0;
                        inst_d.a_xmem   = w_base_q + addr_width'(cnt_q);
                    end
                    inst_d.l0_wr = (cnt_q != '0);
                    if (cnt_q == CNT_W'(row)) begin
                        state_d = S_W_LOAD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_W_LOAD: begin
                    inst_d.l0_rd = 1'b1;
                    inst_d.load  = 1'b1;
                    if (cnt_q == CNT_W'(row - 1)) begin
                        state_d = S_W_FLUSH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_W_FLUSH: begin
                    if (cnt_q == CNT_W'(FLUSH_LEN - 1)) begin
                        state_d = (n_act_q == '0) ? S_DONE : S_X_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_X_RUN: begin
                    if (cnt_q < CNT_W'(n_act_q)) begin
                        inst_d.cen_xmem = 1'b0;
                        inst_d.a_xmem   = x_base_q + addr_width'(cnt_q);
                    end
                    if (cnt_q != '0) begin
                        inst_d.l0_wr   = 1'b1;
                        inst_d.l0_rd   = 1'b1;
                        inst_d.execute = 1'b1;
                    end
                    if (cnt_q == CNT_W'(n_act_q)) begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    // A read granted last cycle always writes pmem this cycle, even if ofifo_valid has dropped.
                    if (wr_pend_q) begin
                        inst_d.cen_pmem = 1'b0;
                        inst_d.wen_pmem = 1'b0;
                        inst_d.a_pmem   = p_base_q + wr_cnt_q;
                        wr_cnt_d        = wr_cnt_q + addr_width'(1);
                        if (wr_cnt_d == n_act_q) begin
                            state_d = S_DONE;
                        end
                    end
                    inst_d.ofifo_rd = ofifo_valid && (rd_cnt_q < n_act_q);
                    if (inst_d.ofifo_rd) begin
                        rd_cnt_d = rd_cnt_q + addr_width'(1);
                    end
                    wr_pend_d = inst_d.ofifo_rd;
                end
                S_DONE: begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            wr_pend_q <= 1'b0;
            w_base_q  <= '0;
            x_base_q  <= '0;
            p_base_q  <= '0;
            n_act_q   <= '0;
            inst_q    <= INST_NOP;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_pend_q <= wr_pend_d;
            w_base_q  <= w_base_d;
            x_base_q  <= x_base_d;
            p_base_q  <= p_base_d;
            n_act_q   <= n_act_d;
            inst_q    <= inst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_core_seq.sv
// Self-checking bench for core_seq: per-cycle comparison of inst/busy/done against a tile-level model.
module tb_core_seq;

    localparam int unsigned ROW = 8;
    localparam int unsigned COL = 8;
    localparam int unsigned AW  = 11;
    localparam logic [33:0] NOP = 34'h1800C0000;

    logic          clk, reset, start, ofifo_valid;
    logic [AW-1:0] w_base, x_base, p_base, n_act;
    logic [33:0]   inst;
    logic          busy, done;
`ifdef CORE_SEQ_PAUSE_EN
    logic          pause;
`endif

    core_seq #(.row(ROW), .col(COL), .addr_width(AW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .w_base(w_base), .x_base(x_base), .p_base(p_base), .n_act(n_act),
        .ofifo_valid(ofifo_valid),
`ifdef CORE_SEQ_PAUSE_EN
        .pause(pause),
`endif
        .inst(inst), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [33:0]   fixed_q[$];
    logic [AW-1:0] xr_q[$];
    logic [AW-1:0] pw_q[$];
    int loads, execs, dones, busy_cyc, rds;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Deterministic part of a tile: weight read, load, flush, activation run.
    task automatic build_fixed(input logic [AW-1:0] w, input logic [AW-1:0] x, input int n);
        logic [33:0] e;
        fixed_q.delete();
        for (int i = 0; i <= int'(ROW); i++) begin
            e = NOP;
            if (i < int'(ROW)) begin e[19] = 1'b0; e[17:7] = w + AW'(i); end
            if (i >= 1) e[2] = 1'b1;
            fixed_q.push_back(e);
        end
        for (int i = 0; i < int'(ROW); i++) begin
            e = NOP; e[3] = 1'b1; e[0] = 1'b1;
            fixed_q.push_back(e);
        end
        for (int i = 0; i < int'(ROW + COL); i++) fixed_q.push_back(NOP);
        if (n > 0) begin
            for (int i = 0; i <= n; i++) begin
                e = NOP;
                if (i < n) begin e[19] = 1'b0; e[17:7] = x + AW'(i); end
                if (i >= 1) begin e[3:1] = 3'b111; end
                fixed_q.push_back(e);
            end
        end
    endtask

    task automatic observe();
        if (inst[19] == 1'b0) xr_q.push_back(inst[17:7]);
        if (inst[32] == 1'b0 && inst[31] == 1'b0) pw_q.push_back(inst[30:20]);
        loads    += int'(inst[0]);
        execs    += int'(inst[1]);
        rds      += int'(inst[6]);
        dones    += int'(done);
        busy_cyc += int'(busy);
    endtask

    // vmode: 0 valid always, 1 toggles 1,0,.. through drain, 2 random every cycle.
    task automatic run_tile(input logic [AW-1:0] w, input logic [AW-1:0] x, input logic [AW-1:0] p,
                            input logic [AW-1:0] n, input int vmode, input int mid_start_at,
                            input int pause_at, input int reset_at);
        int idx, j, reads, writes, dc, nn;
        bit pend, fin, v, paused, r;
        logic [33:0] e;
        logic eb, ed;
        nn = int'(n);
        build_fixed(w, x, nn);
        xr_q.delete(); pw_q.delete();
        loads = 0; execs = 0; dones = 0; busy_cyc = 0; rds = 0;
        w_base = w; x_base = x; p_base = p; n_act = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        w_base = AW'($urandom); x_base = AW'($urandom); p_base = AW'($urandom); n_act = AW'($urandom);
        idx = 0; j = 0; reads = 0; writes = 0; dc = 0; pend = 1'b0; fin = 1'b0;
        while (!fin && j < 4000) begin
            if (j == reset_at) begin
                reset = 1'b1;
                #1;
                check("reset_mid_inst", 64'(inst), 64'(NOP));
                check("reset_mid_busy", 64'(busy), 64'd0);
                @(posedge clk); #1;
                reset = 1'b0;
                pw_q.delete();
                for (int k = 0; k < 30; k++) begin
                    @(posedge clk); #1;
                    observe();
                    check("after_reset_idle", {28'd0, done, busy, inst}, {28'd0, 1'b0, 1'b0, NOP});
                end
                check("after_reset_pmem_writes", 64'(pw_q.size()), 64'd0);
                return;
            end
            paused = (pause_at >= 0) && (j >= pause_at) && (j < pause_at + 5);
`ifdef CORE_SEQ_PAUSE_EN
            pause = paused;
`endif
            if (vmode == 0) v = 1'b1;
            else if (vmode == 1) v = (idx >= fixed_q.size()) ? ((dc % 2) == 0) : 1'b1;
            else v = 1'($urandom);
            ofifo_valid = v;
            start = (j == mid_start_at);
            if (start) begin
                w_base = AW'($urandom); x_base = AW'($urandom); p_base = AW'($urandom); n_act = 11'd3;
            end
            @(posedge clk); #1;
            start = 1'b0;
            eb = 1'b1; ed = 1'b0; e = NOP;
            if (paused) begin
                e = NOP;
            end else if (idx < fixed_q.size()) begin
                e = fixed_q[idx];
                idx++;
            end else if (nn > 0 && writes < nn) begin
                dc++;
                if (pend) begin
                    e[32] = 1'b0; e[31] = 1'b0; e[30:20] = p + AW'(writes);
                    writes++;
                end
                r = v && (reads < nn);
                if (r) begin e[6] = 1'b1; reads++; end
                pend = r;
            end else begin
                ed = 1'b1;
                fin = 1'b1;
            end
            check("cycle_done_busy_inst", {28'd0, done, busy, inst}, {28'd0, ed, eb, e});
            observe();
            j++;
        end
        if (!fin) begin
            checks++; errors++;
            $display("FAIL tile_timeout: got no done after %0d cycles expected done", j);
        end
`ifdef CORE_SEQ_PAUSE_EN
        pause = 1'b0;
`endif
        ofifo_valid = 1'b1;
        @(posedge clk); #1;
        check("post_tile_idle", {28'd0, done, busy, inst}, {28'd0, 1'b0, 1'b0, NOP});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] rw, rx, rp, rn;
        reset = 1'b0; start = 1'b0; ofifo_valid = 1'b1;
        w_base = '0; x_base = '0; p_base = '0; n_act = '0;
`ifdef CORE_SEQ_PAUSE_EN
        pause = 1'b0;
`endif
        #2 reset = 1'b1;
        #1;
        check("reset_inst", 64'(inst), 64'h1800C0000);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("idle_inst", 64'(inst), 64'h1800C0000);

        // Basic tile with hand-computed anchors
        run_tile(11'd0, 11'd16, 11'd100, 11'd4, 0, -1, -1, -1);
        check("basic_xrd_count", 64'(xr_q.size()), 64'd12);
        for (int i = 0; i < 8; i++) check("basic_w_addr", 64'(xr_q[i]), 64'(i));
        for (int i = 0; i < 4; i++) check("basic_x_addr", 64'(xr_q[8 + i]), 64'(16 + i));
        check("basic_loads", 64'(loads), 64'd8);
        check("basic_execs", 64'(execs), 64'd4);
        check("basic_pw_count", 64'(pw_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) check("basic_p_addr", 64'(pw_q[i]), 64'(100 + i));
        check("basic_done_pulses", 64'(dones), 64'd1);
        check("basic_busy_cycles", 64'(busy_cyc), 64'd44);

        // Back-pressure
        run_tile(11'd0, 11'd16, 11'd100, 11'd4, 1, -1, -1, -1);
        check("bp_rd_count", 64'(rds), 64'd4);
        for (int i = 0; i < 4; i++) check("bp_p_addr", 64'(pw_q[i]), 64'(100 + i));
        check("bp_done_pulses", 64'(dones), 64'd1);

        // Wrap with an ignored start mid-tile
        run_tile(11'd5, 11'd2045, 11'd2046, 11'd4, 0, 40, -1, -1);
        check("wrap_pw_count", 64'(pw_q.size()), 64'd4);
        check("wrap_p0", 64'(pw_q[0]), 64'd2046);
        check("wrap_p1", 64'(pw_q[1]), 64'd2047);
        check("wrap_p2", 64'(pw_q[2]), 64'd0);
        check("wrap_p3", 64'(pw_q[3]), 64'd1);
        check("wrap_x_last", 64'(xr_q[11]), 64'd0);

        // Reset during X_RUN
        run_tile(11'd0, 11'd16, 11'd100, 11'd4, 0, -1, -1, 35);

        // Empty tile
        run_tile(11'd3, 11'd9, 11'd50, 11'd0, 0, -1, -1, -1);
        check("empty_xrd_count", 64'(xr_q.size()), 64'd8);
        check("empty_execs", 64'(execs), 64'd0);
        check("empty_pw_count", 64'(pw_q.size()), 64'd0);
        check("empty_busy_cycles", 64'(busy_cyc), 64'd34);
        check("empty_done_pulses", 64'(dones), 64'd1);

`ifdef CORE_SEQ_PAUSE_EN
        run_tile(11'd0, 11'd16, 11'd100, 11'd4, 0, -1, 12, -1);
        check("pause_loads", 64'(loads), 64'd8);
        check("pause_busy_cycles", 64'(busy_cyc), 64'd49);
`endif

        // Randomized tiles with random back-pressure
        for (int t = 0; t < 6; t++) begin
            rw = AW'($urandom); rx = AW'($urandom); rp = AW'($urandom);
            rn = AW'($urandom_range(1, 10));
            run_tile(rw, rx, rp, rn, 2, -1, -1, -1);
            check("rand_pw_count", 64'(pw_q.size()), 64'(rn));
            for (int i = 0; i < pw_q.size(); i++) check("rand_p_addr", 64'(pw_q[i]), 64'(rp + AW'(i)));
            check("rand_done_pulses", 64'(dones), 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
